mbox_word_unpack: RTL and testbench

- Reader end of the MAILBOX byte channel. The wishbone side writes each 32-bit word into the MAILBOX FIFO as four bytes, least-significant byte first.
- This block pops those bytes from the MAILBOX FIFO and reassembles the little-endian 32-bit words.
- It presents each word on a valid/ready interface to the WOU framer.
- It runs entirely in the MAILBOX read-clock domain.

---
 rtl/mbox_word_unpack.sv | 150 +++++++++++++++
 tb/tb_mbox_word_unpack.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mbox_word_unpack.sv
// mbox_word_unpack: pops bytes from the MAILBOX FIFO and reassembles little-endian words for the WOU framer.
// Optional MBOX_UNPACK_TIMEOUT_EN: flush a zero-padded partial word after TIMEOUT idle cycles.
module mbox_word_unpack #(
  parameter int unsigned WB_DW   = 32,
  parameter int unsigned MBOX_DW = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               mbox_empty_i,
  input  logic [MBOX_DW-1:0] mbox_di_i,
  output logic               mbox_rd_o,
  output logic [WB_DW-1:0]   word_o,
  output logic               word_valid_o,
  input  logic               word_ready_i,
  output logic               word_partial_o,
  output logic [CNT_W-1:0]   word_cnt_o
);

  localparam int unsigned LANES  = WB_DW / MBOX_DW;
  localparam int unsigned LCNT_W = 3;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [LCNT_W-1:0]   issue_q, issue_d;
  logic [LCNT_W-1:0]   cap_q, cap_d;
  logic                rd_pend_q;
  logic [WB_DW-1:0]    word_d;
  logic                valid_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                rd_c;

  if (WB_DW != 32 || MBOX_DW * 4 != WB_DW || TIMEOUT < 1) begin : g_bad_cfg
    $error("mbox_word_unpack: unsupported parameter set");
  end

  // Pop whenever filling, data is available and fewer than four bytes have been requested
  assign rd_c      = wb_rst_n_i & (state_q == FILL) & ~mbox_empty_i & (issue_q != LCNT_W'(LANES));
  assign mbox_rd_o = rd_c;

`ifdef MBOX_UNPACK_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             partial_q, partial_d;
  logic             tmo_run_c;

  // Idle with a partially filled word and nothing left in flight
  assign tmo_run_c = (state_q == FILL) && (cap_q != '0) && (cap_q < LCNT_W'(LANES)) &&
                     !rd_pend_q && mbox_empty_i;
  assign word_partial_o = partial_q;
`else
  assign word_partial_o = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    cap_d   = cap_q;
    word_d  = word_o;
    valid_d = word_valid_o;
    cnt_d   = word_cnt_o;
`ifdef MBOX_UNPACK_TIMEOUT_EN
    tmo_d     = '0;
    partial_d = partial_q;
`endif
    case (state_q)
      FILL: begin
        if (rd_c) begin
          issue_d = issue_q + LCNT_W'(1);
        end
        if (rd_pend_q) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            if (cap_q == LCNT_W'(i)) begin
              word_d[i*MBOX_DW +: MBOX_DW] = mbox_di_i;
            end
          end
          cap_d = cap_q + LCNT_W'(1);
          if (cap_q == LCNT_W'(LANES - 1)) begin
            valid_d = 1'b1;
            state_d = HOLD;
            issue_d = '0;
            cap_d   = '0;
          end
        end
`ifdef MBOX_UNPACK_TIMEOUT_EN
        else if (tmo_run_c) begin
          if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            valid_d   = 1'b1;
            partial_d = 1'b1;
            state_d   = HOLD;
            issue_d   = '0;
            cap_d     = '0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
`endif
      end
      HOLD: begin
        if (word_valid_o && word_ready_i) begin
          valid_d = 1'b0;
          cnt_d   = word_cnt_o + CNT_W'(1);
          word_d  = '0;
          state_d = FILL;
`ifdef MBOX_UNPACK_TIMEOUT_EN
          partial_d = 1'b0;
`endif
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= FILL;
      issue_q      <= '0;
      cap_q        <= '0;
      rd_pend_q    <= 1'b0;
      word_o       <= '0;
      word_valid_o <= 1'b0;
      word_cnt_o   <= '0;
`ifdef MBOX_UNPACK_TIMEOUT_EN
      tmo_q     <= '0;
      partial_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      issue_q      <= issue_d;
      cap_q        <= cap_d;
      rd_pend_q    <= rd_c;
      word_o       <= word_d;
      word_valid_o <= valid_d;
      word_cnt_o   <= cnt_d;
`ifdef MBOX_UNPACK_TIMEOUT_EN
      tmo_q     <= tmo_d;
      partial_q <= partial_d;
`endif
    end
  end

endmodule

// File: tb/tb_mbox_word_unpack.sv
// tb_mbox_word_unpack: directed bench with a byte-queue model of the MAILBOX FIFO (one-cycle read latency).
// Honours MBOX_UNPACK_TIMEOUT_EN to pick the partial-flush or wait-forever expectations.
module tb_mbox_word_unpack;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned MBOX_DW = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 8;
`ifdef MBOX_UNPACK_TIMEOUT_EN
  localparam int unsigned STALL = 5;
`else
  localparam int unsigned STALL = 20;
`endif

  logic               wb_clk_i = 1'b0;
  logic               wb_rst_n_i = 1'b0;
  logic               mbox_empty_i = 1'b0;
  logic [MBOX_DW-1:0] mbox_di_i = '0;
  logic               mbox_rd_o;
  logic [WB_DW-1:0]   word_o;
  logic               word_valid_o;
  logic               word_ready_i = 1'b0;
  logic               word_partial_o;
  logic [CNT_W-1:0]   word_cnt_o;

  mbox_word_unpack #(
    .WB_DW  (WB_DW),
    .MBOX_DW(MBOX_DW),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_n_i    (wb_rst_n_i),
    .mbox_empty_i  (mbox_empty_i),
    .mbox_di_i     (mbox_di_i),
    .mbox_rd_o     (mbox_rd_o),
    .word_o        (word_o),
    .word_valid_o  (word_valid_o),
    .word_ready_i  (word_ready_i),
    .word_partial_o(word_partial_o),
    .word_cnt_o    (word_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  logic [MBOX_DW-1:0] fifo_q[$];
  int                 n_checks;
  int                 n_fail;
  int unsigned        exp_cnt;
  logic               s_rd, s_valid, s_partial;
  logic [WB_DW-1:0]   s_word;
  logic [CNT_W-1:0]   s_cnt;
  logic [15:0]        rd_bits, v_bits;
  logic [WB_DW-1:0]   w_cap, w_exp;
  logic               p_cap;
  int                 v_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, then update the FIFO model just after the edge
  task automatic step();
    @(negedge wb_clk_i);
    s_rd      = mbox_rd_o;
    s_valid   = word_valid_o;
    s_partial = word_partial_o;
    s_word    = word_o;
    s_cnt     = word_cnt_o;
    check("rd_while_empty", 32'(mbox_rd_o & mbox_empty_i), 32'd0);
    @(posedge wb_clk_i);
    #1;
    if (s_rd && fifo_q.size() > 0) mbox_di_i = fifo_q.pop_front();
    mbox_empty_i = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [MBOX_DW-1:0] b);
    fifo_q.push_back(b);
    mbox_empty_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!s_valid && n < max);
    check({tag, "_valid"}, 32'(s_valid), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_word"}, word_o, 32'd0);
    check({tag, "_valid"}, 32'(word_valid_o), 32'd0);
    check({tag, "_partial"}, 32'(word_partial_o), 32'd0);
    check({tag, "_cnt"}, 32'(word_cnt_o), 32'd0);
    check({tag, "_rd"}, 32'(mbox_rd_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;

    // Reset values, with empty low to show the pop strobe stays quiet in reset
    #12;
    check_outputs_zero("rst");
    mbox_empty_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    wb_rst_n_i   = 1'b1;
    word_ready_i = 1'b1;
    step();
    step();

    // Single word, exact pop and valid timing
    push(8'h78); push(8'h56); push(8'h34); push(8'h12);
    rd_bits = '0; v_bits = '0; w_cap = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      rd_bits[i] = s_rd;
      v_bits[i]  = s_valid;
      if (s_valid) begin
        w_cap = s_word;
        p_cap = s_partial;
      end
    end
    exp_cnt = 1;
    check("t1_rd_pattern", 32'(rd_bits), 32'h0000_000F);
    check("t1_valid_pattern", 32'(v_bits), 32'h0000_0020);
    check("t1_word", w_cap, 32'h1234_5678);
    check("t1_partial", 32'(p_cap), 32'd0);
    check("t1_cnt", 32'(s_cnt), 32'(CNT_W'(exp_cnt)));

    // Backpressure: first word held, no pops in HOLD
    word_ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_valid("t2a", 20);
    check("t2a_word", s_word, 32'h0403_0201);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_hold_word", s_word, 32'h0403_0201);
      check("t2_hold_valid", 32'(s_valid), 32'd1);
      check("t2_hold_rd", 32'(s_rd), 32'd0);
    end
    word_ready_i = 1'b1;
    step();
    exp_cnt++;
    wait_valid("t2b", 20);
    check("t2b_word", s_word, 32'h0807_0605);
    exp_cnt++;
    step();
    check("t2_after_valid", 32'(s_valid), 32'd0);
    check("t2_cnt", 32'(s_cnt), 32'(CNT_W'(exp_cnt)));

    // FIFO runs dry mid-word
    push(8'hC1); push(8'hC2);
    for (int i = 0; i < int'(STALL); i++) step();
    check("t3_no_valid", 32'(s_valid), 32'd0);
    push(8'hC3); push(8'hC4);
    wait_valid("t3", 20);
    check("t3_word", s_word, 32'hC4C3_C2C1);
    check("t3_partial", 32'(s_partial), 32'd0);
    exp_cnt++;
    step();
    check("t3_cnt", 32'(s_cnt), 32'(CNT_W'(exp_cnt)));

    // Reset with two lanes captured and the third byte in flight
    push(8'h11); push(8'h22); push(8'h33);
    step(); step(); step();
    wb_rst_n_i = 1'b0;
    #1;
    check_outputs_zero("t4_rst");
    exp_cnt = 0;
    step();
    step();
    wb_rst_n_i = 1'b1;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    wait_valid("t4", 20);
    check("t4_word", s_word, 32'hA4A3_A2A1);
    exp_cnt++;
    step();
    check("t4_cnt", 32'(s_cnt), 32'(CNT_W'(exp_cnt)));

    // Sixteen words through a 4-bit counter
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 4; j++) push(8'(64 + 4 * k + j));
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 4; j++) w_exp[8*j +: 8] = 8'(64 + 4 * k + j);
      wait_valid($sformatf("t5_w%0d", k), 20);
      check($sformatf("t5_word%0d", k), s_word, w_exp);
      check($sformatf("t5_cnt%0d", k), 32'(s_cnt), 32'(CNT_W'(exp_cnt)));
      exp_cnt++;
    end
    step();
    check("t5_cnt_final", 32'(s_cnt), 32'(CNT_W'(exp_cnt)));

    // Two bytes then starvation
    push(8'hAA); push(8'hBB);
`ifdef MBOX_UNPACK_TIMEOUT_EN
    v_bits = '0; w_cap = '0; p_cap = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      v_bits[i] = s_valid;
      if (s_valid) begin
        w_cap = s_word;
        p_cap = s_partial;
      end
    end
    check("t6_valid_pattern", 32'(v_bits), 32'h0000_0800);
    check("t6_word", w_cap, 32'h0000_BBAA);
    check("t6_partial", 32'(p_cap), 32'd1);
    exp_cnt++;
    check("t6_partial_cleared", 32'(s_partial), 32'd0);
`else
    v_count = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s_valid) v_count++;
    end
    check("t6_no_valid", 32'(v_count), 32'd0);
    push(8'hCC); push(8'hDD);
    wait_valid("t6", 20);
    check("t6_word", s_word, 32'hDDCC_BBAA);
    check("t6_partial", 32'(s_partial), 32'd0);
    exp_cnt++;
    step();
`endif
    check("t6_cnt", 32'(s_cnt), 32'(CNT_W'(exp_cnt)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
